kgp_mc_controller: RTL and testbench
====================================

KGP_MC_CONTROLLER -- requirements
Module: kgp_mc_controller

Interface
REQ-001 Parameter DATA_W, default 32, instruction width (>=32); opcode = instr[DATA_W-1:DATA_W-6], funct = instr[5:0].
REQ-002 Parameter FUNC_W, default 4, alufunc width (>=4); codes zero-extended.
REQ-003 Parameter TIMEOUT, default 15, maximum wait cycles for a memory ack before fault.
REQ-004 clk  input  1  clock, rising edge.
REQ-005 reset  input  1  reset, asynchronous, active-high.
REQ-006 instr  input  DATA_W  IR contents; sampled only in ID.
REQ-007 imem_ack  input  1  instruction memory done.
REQ-008 dmem_ack  input  1  data memory done.
REQ-009 cond_ok  input  1  branch condition result from datapath.
REQ-010 imem_req  output  1  instruction fetch request.
REQ-011 dmem_rd / dmem_wr  output  1 each  data memory read / write request.
REQ-012 ldir_npc  output  1  load IR and NPC.
REQ-013 ld_ops  output  3  {ldA, ldB, ldimm}.
REQ-014 alusel  output  2  {alusel1, alusel2} operand select.
REQ-015 alufunc  output  FUNC_W  ALU operation.
REQ-016 ldaluout  output  1  load ALU output register.
REQ-017 opcond  output  2  branch condition select.
REQ-018 regwrite, ldlmd, selwb, ldpc, branch  output  1 each  writeback, LMD load, WB mux (1=LMD), PC load, PC source (1=target).
REQ-019 state  output  3  current state code.
REQ-020 fault  output  1  sticky illegal-instruction/timeout flag.

Function
REQ-021 States: IF=0, ID=1, EX=2, MEM=3, WB=4, FAULT=7; all outputs decoded from state plus instruction fields registered in ID.
REQ-022 IF: imem_req=1 until imem_ack; in the ack cycle, ldir_npc=1 and next state ID.
REQ-023 ID: ld_ops=3'b111 for one cycle; latch class (opcode[5:4]), alufunc, opcond; next state EX, or FAULT if illegal.
REQ-024 R-class (00): funct 1..10 maps to alufunc 0..9; other funct values are illegal; alusel=2'b10.
REQ-025 I-class (01): opcode 010000..011001 maps to alufunc 0..9; MOVE (011010) maps to 0; others are illegal; alusel=2'b11.
REQ-026 Memory class: LD=100001, ST=100010, alufunc=0, alusel=2'b11; other 10xxxx opcodes are illegal.
REQ-027 Branch class: BR=110000 (opcond 11, unconditional), BMI=110001 (01), BPL=110010 (00), BZ=110011 (10), alufunc=4'b1010, alusel=2'b01; others are illegal.
REQ-028 EX: aluen=1, ldaluout=1 for one cycle; R/I go to WB, LD/ST go to MEM.
REQ-029 Branch EX: ldpc=1, branch = (BR ? 1 : cond_ok) in the same cycle; next state IF; no writeback.
REQ-030 MEM: dmem_rd (LD) or dmem_wr (ST) is held until dmem_ack; LD ack cycle: ldlmd=1, go to WB; ST ack cycle: ldpc=1, branch=0, go to IF.
REQ-031 WB: regwrite=1, selwb=1 for LD else 0, ldpc=1, branch=0; next state IF.
REQ-032 Wait counter clears on entry to IF/MEM and increments each cycle without ack; if it reaches TIMEOUT with no ack, deassert the request and go to FAULT.
REQ-033 Ack arriving in the same cycle that the counter reaches TIMEOUT: the ack wins.
REQ-034 Acks outside IF/MEM are ignored; instr changes after ID do not affect the instruction in flight.
REQ-035 FAULT: all strobes 0, fault=1, held until reset.
REQ-036 Latency with ack in first request cycle: R/I 4 cycles, LD 5, ST 4, branch 3 (IF entry to next IF entry).
REQ-037 At most one of imem_req, dmem_rd, dmem_wr is high in any cycle.

Reset
REQ-038 reset=1 immediately forces state=IF, all outputs 0, fault=0, counter 0, including mid-MEM (requests drop asynchronously).
REQ-039 First clock after reset release: imem_req=1.

Verification
REQ-040 ADD (class 00, funct 000001), imem_ack in first cycle -> IF,ID,EX,WB; alufunc=0, alusel=10, regwrite=1 in cycle 4, selwb=0.
REQ-041 LD with dmem_ack delayed 3 cycles -> dmem_rd high 4 cycles, ldlmd=1 in ack cycle, WB with selwb=1, regwrite=1.
REQ-042 BZ with cond_ok=0, then BR with cond_ok=0 -> BZ: ldpc=1, branch=0, opcond=10; BR: branch=1, opcond=11; no regwrite.
REQ-043 imem_ack never asserted, TIMEOUT=15 -> FAULT after 15 wait cycles, imem_req=0, fault=1 held; illegal funct 111111 -> FAULT from ID.
REQ-044 reset pulsed during ST in MEM -> dmem_wr=0 at once; after release state=IF, imem_req=1, fault=0.

Source files
------------

// File: rtl/kgp_mc_controller.sv
// Multicycle CPU control FSM: IF/ID/EX/MEM/WB sequencing, per-request ack timeout, sticky fault state.
// Strobes decode from the registered state plus instruction fields captured in ID; reset forces all outputs low.
module kgp_mc_controller #(
    parameter int DATA_W  = 32,
    parameter int FUNC_W  = 4,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] instr,
    input  logic              imem_ack,
    input  logic              dmem_ack,
    input  logic              cond_ok,
    output logic              imem_req,
    output logic              dmem_rd,
    output logic              dmem_wr,
    output logic              ldir_npc,
    output logic [2:0]        ld_ops,
    output logic [1:0]        alusel,
    output logic [FUNC_W-1:0] alufunc,
    output logic              ldaluout,
    output logic [1:0]        opcond,
    output logic              regwrite,
    output logic              ldlmd,
    output logic              selwb,
    output logic              ldpc,
    output logic              branch,
    output logic [2:0]        state,
    output logic              fault
);
    typedef enum logic [2:0] {
        S_IF    = 3'd0,
        S_ID    = 3'd1,
        S_EX    = 3'd2,
        S_MEM   = 3'd3,
        S_WB    = 3'd4,
        S_FAULT = 3'd7
    } state_t;

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       cls_q, sel_q, cond_q;
    logic [3:0]       func_q;
    logic             is_ld_q, uncond_q;

    logic [5:0] opc, fn;
    logic [3:0] dec_func;
    logic [1:0] dec_sel, dec_cond;
    logic       dec_ill, dec_ld, dec_uncond;
    logic       unused_instr;

    assign opc          = instr[DATA_W-1 -: 6];
    assign fn           = instr[5:0];
    assign unused_instr = ^instr[DATA_W-7:6];

    always_comb begin
        dec_ill    = 1'b0;
        dec_func   = 4'd0;
        dec_sel    = 2'b00;
        dec_cond   = 2'b00;
        dec_ld     = 1'b0;
        dec_uncond = 1'b0;
        case (opc[5:4])
            2'b00: begin
                dec_sel = 2'b10;
                if (fn >= 6'd1 && fn <= 6'd10) dec_func = fn[3:0] - 4'd1;
                else                           dec_ill  = 1'b1;
            end
            2'b01: begin
                dec_sel = 2'b11;
                if (opc <= 6'h19)      dec_func = opc[3:0];
                else if (opc != 6'h1A) dec_ill  = 1'b1;
            end
            2'b10: begin
                dec_sel = 2'b11;
                case (opc)
                    6'h21:   dec_ld  = 1'b1;
                    6'h22:   dec_ld  = 1'b0;
                    default: dec_ill = 1'b1;
                endcase
            end
            default: begin
                dec_sel  = 2'b01;
                dec_func = 4'd10;
                case (opc)
                    6'h30: begin dec_cond = 2'b11; dec_uncond = 1'b1; end
                    6'h31: dec_cond = 2'b01;
                    6'h32: dec_cond = 2'b00;
                    6'h33: dec_cond = 2'b10;
                    default: dec_ill = 1'b1;
                endcase
            end
        endcase
    end

    // The wait counter is zero in every state except while a request is outstanding.
    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        case (state_q)
            S_IF: begin
                if (imem_ack)               state_d = S_ID;
                else if (cnt_q == CNT_LAST) state_d = S_FAULT;
                else                        cnt_d   = cnt_q + 1'b1;
            end
            S_ID: state_d = dec_ill ? S_FAULT : S_EX;
            S_EX: begin
                case (cls_q)
                    2'b10:   state_d = S_MEM;
                    2'b11:   state_d = S_IF;
                    default: state_d = S_WB;
                endcase
            end
            S_MEM: begin
                if (dmem_ack)               state_d = is_ld_q ? S_WB : S_IF;
                else if (cnt_q == CNT_LAST) state_d = S_FAULT;
                else                        cnt_d   = cnt_q + 1'b1;
            end
            S_WB:    state_d = S_IF;
            S_FAULT: state_d = S_FAULT;
            default: state_d = S_FAULT;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IF;
            cnt_q    <= '0;
            cls_q    <= 2'b00;
            sel_q    <= 2'b00;
            cond_q   <= 2'b00;
            func_q   <= 4'd0;
            is_ld_q  <= 1'b0;
            uncond_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (state_q == S_ID) begin
                cls_q    <= opc[5:4];
                sel_q    <= dec_sel;
                cond_q   <= dec_cond;
                func_q   <= dec_func;
                is_ld_q  <= dec_ld;
                uncond_q <= dec_uncond;
            end
        end
    end

    always_comb begin
        imem_req = 1'b0;
        dmem_rd  = 1'b0;
        dmem_wr  = 1'b0;
        ldir_npc = 1'b0;
        ld_ops   = 3'b000;
        alusel   = 2'b00;
        alufunc  = '0;
        ldaluout = 1'b0;
        opcond   = 2'b00;
        regwrite = 1'b0;
        ldlmd    = 1'b0;
        selwb    = 1'b0;
        ldpc     = 1'b0;
        branch   = 1'b0;
        fault    = 1'b0;
        if (!reset) begin
            case (state_q)
                S_IF: begin
                    imem_req = 1'b1;
                    ldir_npc = imem_ack;
                end
                S_ID: ld_ops = 3'b111;
                S_EX: begin
                    ldaluout     = 1'b1;
                    alusel       = sel_q;
                    alufunc[3:0] = func_q;
                    opcond       = cond_q;
                    if (cls_q == 2'b11) begin
                        ldpc   = 1'b1;
                        branch = uncond_q | cond_ok;
                    end
                end
                S_MEM: begin
                    dmem_rd = is_ld_q;
                    dmem_wr = !is_ld_q;
                    ldlmd   = is_ld_q & dmem_ack;
                    ldpc    = !is_ld_q & dmem_ack;
                end
                S_WB: begin
                    regwrite = 1'b1;
                    selwb    = is_ld_q;
                    ldpc     = 1'b1;
                end
                S_FAULT: fault = 1'b1;
                default: ;
            endcase
        end
    end

    assign state = state_q;
endmodule

// File: tb/tb_kgp_mc_controller.sv
// Randomized bench for kgp_mc_controller: instruction-level reference model predicts every cycle's outputs.
module tb_kgp_mc_controller;
    localparam int DATA_W  = 32;
    localparam int FUNC_W  = 4;
    localparam int TIMEOUT = 15;

    logic              clk = 1'b0;
    logic              reset, imem_ack, dmem_ack, cond_ok;
    logic [DATA_W-1:0] instr;
    logic              imem_req, dmem_rd, dmem_wr, ldir_npc, ldaluout;
    logic [2:0]        ld_ops, state;
    logic [1:0]        alusel, opcond;
    logic [FUNC_W-1:0] alufunc;
    logic              regwrite, ldlmd, selwb, ldpc, branch, fault;

    kgp_mc_controller #(.DATA_W(DATA_W), .FUNC_W(FUNC_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset), .instr(instr), .imem_ack(imem_ack), .dmem_ack(dmem_ack),
        .cond_ok(cond_ok), .imem_req(imem_req), .dmem_rd(dmem_rd), .dmem_wr(dmem_wr),
        .ldir_npc(ldir_npc), .ld_ops(ld_ops), .alusel(alusel), .alufunc(alufunc),
        .ldaluout(ldaluout), .opcond(opcond), .regwrite(regwrite), .ldlmd(ldlmd),
        .selwb(selwb), .ldpc(ldpc), .branch(branch), .state(state), .fault(fault)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0] st;
        logic       ireq, drd, dwr, ldir;
        logic [2:0] ops;
        logic [1:0] sel;
        logic [3:0] fn;
        logic       alo;
        logic [1:0] oc;
        logic       rw, lmd, swb, lpc, br, flt;
    } outv_t;

    typedef struct packed {
        bit         legal, ld, st, br, uncond;
        logic [1:0] sel, oc;
        logic [3:0] fn;
    } dec_t;

    outv_t obs;
    assign obs = {state, imem_req, dmem_rd, dmem_wr, ldir_npc, ld_ops, alusel, alufunc,
                  ldaluout, opcond, regwrite, ldlmd, selwb, ldpc, branch, fault};

    int   n_checks = 0;
    int   n_pass   = 0;
    logic faulted;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    endtask

    // Reference decode straight from the ISA tables.
    function automatic dec_t ref_decode(input logic [31:0] ins);
        int   opc, f;
        dec_t d;
        opc = int'(ins[31:26]);
        f   = int'(ins[5:0]);
        d   = '0;
        case (opc / 16)
            0: begin d.legal = (f >= 1 && f <= 10); d.fn = 4'(f - 1); d.sel = 2'b10; end
            1: begin d.legal = (opc <= 26); d.fn = (opc == 26) ? 4'd0 : 4'(opc - 16); d.sel = 2'b11; end
            2: begin d.ld = (opc == 33); d.st = (opc == 34); d.legal = d.ld || d.st; d.sel = 2'b11; end
            default: begin
                d.br = 1'b1; d.legal = (opc <= 51); d.fn = 4'd10; d.sel = 2'b01; d.uncond = (opc == 48);
                case (opc)
                    48:      d.oc = 2'b11;
                    49:      d.oc = 2'b01;
                    50:      d.oc = 2'b00;
                    default: d.oc = 2'b10;
                endcase
            end
        endcase
        return d;
    endfunction

    task automatic noise();
        imem_ack = 1'($urandom);
        dmem_ack = 1'($urandom);
        cond_ok  = 1'($urandom);
        instr    = $urandom;
    endtask

    task automatic expect_fault(input string tag);
        outv_t e;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); noise(); #1;
            e = '0; e.st = 3'd7; e.flt = 1'b1;
            check_eq(tag, 32'(obs), 32'(e));
        end
        faulted = 1'b1;
    endtask

    task automatic pulse_reset();
        outv_t e;
        @(negedge clk); reset = 1'b1; noise(); #1;
        e = '0;
        check_eq("reset", 32'(obs), 32'(e));
        @(posedge clk); #1;
        reset = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0;
    endtask

    // Runs one instruction from IF entry; delays are counted in wait cycles before the ack.
    task automatic run_instr(input logic [31:0] ins, input int idly, input int ddly,
                             input logic cond, input int rst_at);
        dec_t  d;
        outv_t e;
        logic  ack;
        d = ref_decode(ins);
        faulted = 1'b0;
        for (int k = 0; k < TIMEOUT; k++) begin
            @(negedge clk); noise(); ack = (k == idly); imem_ack = ack; #1;
            e = '0; e.ireq = 1'b1; e.ldir = ack;
            check_eq("IF", 32'(obs), 32'(e));
            if (ack) break;
        end
        if (idly >= TIMEOUT) begin expect_fault("IF timeout"); return; end

        @(negedge clk); noise(); instr = ins; #1;
        e = '0; e.st = 3'd1; e.ops = 3'b111;
        check_eq("ID", 32'(obs), 32'(e));
        if (!d.legal) begin expect_fault("illegal"); return; end

        @(negedge clk); noise(); cond_ok = cond; #1;
        e = '0; e.st = 3'd2; e.alo = 1'b1; e.sel = d.sel; e.fn = d.fn; e.oc = d.oc;
        if (d.br) begin e.lpc = 1'b1; e.br = d.uncond | cond; end
        check_eq("EX", 32'(obs), 32'(e));
        if (d.br) return;

        if (d.ld || d.st) begin
            for (int k = 0; k < TIMEOUT; k++) begin
                @(negedge clk); noise(); ack = (k == ddly); dmem_ack = ack; #1;
                e = '0; e.st = 3'd3; e.drd = d.ld; e.dwr = d.st;
                e.lmd = ack & d.ld; e.lpc = ack & d.st;
                check_eq("MEM", 32'(obs), 32'(e));
                if (k == rst_at) begin
                    reset = 1'b1; #1;
                    e = '0;
                    check_eq("reset in MEM", 32'(obs), 32'(e));
                    @(posedge clk); #1;
                    reset = 1'b0; imem_ack = 1'b0; #1;
                    e = '0; e.ireq = 1'b1;
                    check_eq("IF after reset", 32'(obs), 32'(e));
                    return;
                end
                if (ack) break;
            end
            if (ddly >= TIMEOUT) begin expect_fault("MEM timeout"); return; end
            if (d.st) return;
        end

        @(negedge clk); noise(); #1;
        e = '0; e.st = 3'd4; e.rw = 1'b1; e.swb = d.ld; e.lpc = 1'b1;
        check_eq("WB", 32'(obs), 32'(e));
    endtask

    task automatic run_and_recover(input logic [31:0] ins, input int idly, input int ddly,
                                   input logic cond, input int rst_at);
        run_instr(ins, idly, ddly, cond, rst_at);
        if (faulted) pulse_reset();
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] r;
        int          pick;
        r    = $urandom;
        pick = $urandom_range(0, 15);
        if (pick <= 3)       begin r[31:26] = {2'b00, 4'($urandom)}; r[5:0] = 6'($urandom_range(1, 10)); end
        else if (pick <= 6)  r[31:26] = 6'($urandom_range(16, 26));
        else if (pick <= 9)  r[31:26] = ($urandom_range(0, 1) == 1) ? 6'h21 : 6'h22;
        else if (pick <= 13) r[31:26] = 6'($urandom_range(48, 51));
        return r;
    endfunction

    function automatic int rand_dly();
        int p;
        p = $urandom_range(0, 19);
        if (p == 0) return TIMEOUT - 1;
        if (p == 1) return TIMEOUT;
        return $urandom_range(0, 3);
    endfunction

    initial begin
        reset = 1'b1; imem_ack = 1'b0; dmem_ack = 1'b0; cond_ok = 1'b0; instr = '0;
        repeat (2) @(posedge clk);
        pulse_reset();

        run_and_recover({6'b000000, 20'h00000, 6'b000001}, 0, 0, 1'b0, -1);  // ADD
        run_and_recover({6'b100001, 26'h0}, 0, 3, 1'b0, -1);                  // LD, late ack
        run_and_recover({6'b110011, 26'h0}, 0, 0, 1'b0, -1);                  // BZ not taken
        run_and_recover({6'b110000, 26'h0}, 0, 0, 1'b0, -1);                  // BR always taken
        run_and_recover({6'b011010, 26'h155}, 1, 0, 1'b0, -1);                // MOVE
        run_and_recover({6'b000000, 20'h00000, 6'b000001}, TIMEOUT - 1, 0, 1'b0, -1);
        run_and_recover({6'b000000, 20'h00000, 6'b000001}, TIMEOUT, 0, 1'b0, -1);
        run_and_recover({6'b000000, 20'h00000, 6'b111111}, 0, 0, 1'b0, -1);  // illegal funct
        run_and_recover({6'b100010, 26'h0}, 0, 8, 1'b0, 2);                   // ST, reset in MEM
        run_and_recover({6'b100010, 26'h0}, 0, TIMEOUT - 1, 1'b0, -1);
        run_and_recover({6'b100001, 26'h0}, 0, TIMEOUT, 1'b0, -1);

        for (int i = 0; i < 300; i++)
            run_and_recover(rand_instr(), rand_dly(), rand_dly(), 1'($urandom), -1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
